// File: rtl/latency_busy_table.sv
// rtl/latency_busy_table.sv - per-preg ready/spec/latency-countdown scoreboard with wakeup bypass
module latency_busy_table #(
    parameter int PREG_SIZE  = 128,
    parameter int PREG_WIDTH = $clog2(PREG_SIZE),
    parameter int DIS_NUM    = 4,
    parameter int RD_PORT    = 8,
    parameter int WAKEUP_NUM = 4,
    parameter int SPEC_NUM   = 2,
    parameter int WALK_NUM   = 4,
    parameter int MAX_LAT    = 3,
    parameter int LAT_W      = $clog2(MAX_LAT + 1)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           redirect,
    input  logic [DIS_NUM-1:0]             dis_en,
    input  logic [DIS_NUM*PREG_WIDTH-1:0]  dis_rd,
    input  logic [WAKEUP_NUM-1:0]          wk_en,
    input  logic [WAKEUP_NUM*PREG_WIDTH-1:0] wk_rd,
    input  logic [SPEC_NUM-1:0]            spec_en,
    input  logic [SPEC_NUM*PREG_WIDTH-1:0] spec_rd,
    input  logic [SPEC_NUM*LAT_W-1:0]      spec_lat,
    input  logic [SPEC_NUM-1:0]            cancel_en,
    input  logic [SPEC_NUM*PREG_WIDTH-1:0] cancel_rd,
    input  logic [WALK_NUM-1:0]            walk_en,
    input  logic [WALK_NUM*PREG_WIDTH-1:0] walk_rd,
    input  logic [RD_PORT*PREG_WIDTH-1:0]  rd_preg,
    output logic [RD_PORT-1:0]             rd_ready,
    output logic [RD_PORT-1:0]             rd_spec,
    output logic [PREG_WIDTH:0]            busy_cnt
);

    localparam logic [LAT_W-1:0] LAT_SAT = LAT_W'(MAX_LAT);

    logic [PREG_SIZE-1:0] ready_q, ready_d;
    logic [PREG_SIZE-1:0] spec_q, spec_d;
    logic [LAT_W-1:0]     cnt_q [PREG_SIZE];
    logic [LAT_W-1:0]     cnt_d [PREG_SIZE];
    logic [PREG_WIDTH:0]  busy_cnt_q, busy_cnt_d;

    function automatic logic [LAT_W-1:0] sat_lat(input logic [LAT_W-1:0] l);
        return (32'(l) > MAX_LAT) ? LAT_SAT : l;
    endfunction

    always_comb begin
        logic             dis_hit, can_hit, wk_hit, sch_hit;
        logic [LAT_W-1:0] sch_lat;
        busy_cnt_d = '0;
        for (int p = 0; p < PREG_SIZE; p++) begin
            dis_hit = 1'b0;
            can_hit = 1'b0;
            wk_hit  = 1'b0;
            sch_hit = 1'b0;
            sch_lat = '0;
            for (int i = 0; i < DIS_NUM; i++)
                if (dis_en[i] && dis_rd[i*PREG_WIDTH +: PREG_WIDTH] == PREG_WIDTH'(p)) dis_hit = 1'b1;
            for (int i = 0; i < WAKEUP_NUM; i++)
                if (wk_en[i] && wk_rd[i*PREG_WIDTH +: PREG_WIDTH] == PREG_WIDTH'(p)) wk_hit = 1'b1;
            for (int i = 0; i < WALK_NUM; i++)
                if (walk_en[i] && walk_rd[i*PREG_WIDTH +: PREG_WIDTH] == PREG_WIDTH'(p)) wk_hit = 1'b1;
            for (int i = 0; i < SPEC_NUM; i++) begin
                if (cancel_en[i] && cancel_rd[i*PREG_WIDTH +: PREG_WIDTH] == PREG_WIDTH'(p)) can_hit = 1'b1;
                if (spec_en[i] && spec_rd[i*PREG_WIDTH +: PREG_WIDTH] == PREG_WIDTH'(p)) begin
                    sch_hit = 1'b1;
                    sch_lat = sch_lat | sat_lat(spec_lat[i*LAT_W +: LAT_W]);
                end
            end

            ready_d[p] = ready_q[p];
            spec_d[p]  = spec_q[p];
            cnt_d[p]   = cnt_q[p];
            if (dis_hit && !redirect) begin
                ready_d[p] = 1'b0;
                spec_d[p]  = 1'b0;
                cnt_d[p]   = '0;
            end else if (can_hit && (spec_q[p] || cnt_q[p] != '0)) begin
                ready_d[p] = 1'b0;
                spec_d[p]  = 1'b0;
                cnt_d[p]   = '0;
            end else if (wk_hit) begin
                ready_d[p] = 1'b1;
                spec_d[p]  = 1'b0;
                cnt_d[p]   = '0;
            end else if (cnt_q[p] != '0) begin
                // an in-flight countdown owns the entry; a fresh schedule cannot restart it
                cnt_d[p] = cnt_q[p] - 1'b1;
                if (cnt_q[p] == LAT_W'(1)) begin
                    ready_d[p] = 1'b1;
                    spec_d[p]  = 1'b1;
                end
            end else if (sch_hit && !(ready_q[p] && !spec_q[p])) begin
                if (sch_lat == '0) begin
                    ready_d[p] = 1'b1;
                    spec_d[p]  = 1'b1;
                end else begin
                    cnt_d[p] = sch_lat;
                end
            end
            busy_cnt_d = busy_cnt_d + {{PREG_WIDTH{1'b0}}, ~ready_d[p]};
        end
    end

    always_comb begin
        logic [PREG_WIDTH-1:0] idx;
        logic                  byp;
        rd_ready = '0;
        rd_spec  = '0;
        for (int j = 0; j < RD_PORT; j++) begin
            idx = rd_preg[j*PREG_WIDTH +: PREG_WIDTH];
            byp = 1'b0;
            for (int w = 0; w < WAKEUP_NUM; w++)
                if (wk_en[w] && wk_rd[w*PREG_WIDTH +: PREG_WIDTH] == idx) byp = 1'b1;
            rd_ready[j] = ready_q[idx] | byp;
            rd_spec[j]  = spec_q[idx] & ~byp;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_q    <= '1;
            spec_q     <= '0;
            busy_cnt_q <= '0;
            for (int p = 0; p < PREG_SIZE; p++) cnt_q[p] <= '0;
        end else begin
            ready_q    <= ready_d;
            spec_q     <= spec_d;
            busy_cnt_q <= busy_cnt_d;
            for (int p = 0; p < PREG_SIZE; p++) cnt_q[p] <= cnt_d[p];
        end
    end

    assign busy_cnt = busy_cnt_q;

endmodule

// File: tb/tb_latency_busy_table.sv
// tb/tb_latency_busy_table.sv - directed table-driven bench for latency_busy_table
module tb_latency_busy_table;

    localparam int PW  = 7;
    localparam int DN  = 4;
    localparam int RP  = 8;
    localparam int WN  = 4;
    localparam int SN  = 2;
    localparam int LN  = 4;
    localparam int LW  = 3;

    logic                clk, rst, redirect;
    logic [DN-1:0]       dis_en;
    logic [DN*PW-1:0]    dis_rd;
    logic [WN-1:0]       wk_en;
    logic [WN*PW-1:0]    wk_rd;
    logic [SN-1:0]       spec_en;
    logic [SN*PW-1:0]    spec_rd;
    logic [SN*LW-1:0]    spec_lat;
    logic [SN-1:0]       cancel_en;
    logic [SN*PW-1:0]    cancel_rd;
    logic [LN-1:0]       walk_en;
    logic [LN*PW-1:0]    walk_rd;
    logic [RP*PW-1:0]    rd_preg;
    logic [RP-1:0]       rd_ready, rd_spec;
    logic [PW:0]         busy_cnt;

    latency_busy_table #(.MAX_LAT(3), .LAT_W(LW)) dut (
        .clk(clk), .rst(rst), .redirect(redirect),
        .dis_en(dis_en), .dis_rd(dis_rd),
        .wk_en(wk_en), .wk_rd(wk_rd),
        .spec_en(spec_en), .spec_rd(spec_rd), .spec_lat(spec_lat),
        .cancel_en(cancel_en), .cancel_rd(cancel_rd),
        .walk_en(walk_en), .walk_rd(walk_rd),
        .rd_preg(rd_preg), .rd_ready(rd_ready), .rd_spec(rd_spec),
        .busy_cnt(busy_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // kind: 0 idle, 1 dispatch, 2 wakeup, 3 schedule, 4 cancel, 5 walk,
    //       6 dispatch+wakeup, 7 dispatch under redirect + walk
    typedef struct {
        int          kind;
        int          preg;
        int          lat;
        int          q;
        logic        er;
        logic        es;
        int          eb;
    } vec_t;

    vec_t tbl[$];
    int   n_chk = 0;
    int   n_fail = 0;

    function automatic vec_t mk(int kind, int preg, int lat, int q, logic er, logic es, int eb);
        vec_t v;
        v.kind = kind; v.preg = preg; v.lat = lat; v.q = q;
        v.er = er; v.es = es; v.eb = eb;
        return v;
    endfunction

    task automatic chk(string name, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_in();
        redirect = 0; dis_en = '0; dis_rd = '0; wk_en = '0; wk_rd = '0;
        spec_en = '0; spec_rd = '0; spec_lat = '0; cancel_en = '0; cancel_rd = '0;
        walk_en = '0; walk_rd = '0;
    endtask

    task automatic set_q(int q);
        for (int j = 0; j < RP; j++) rd_preg[j*PW +: PW] = PW'(q);
    endtask

    task automatic apply(vec_t v);
        clear_in();
        set_q(v.q);
        case (v.kind)
            1: begin dis_en[0] = 1; dis_rd[PW-1:0] = PW'(v.preg); end
            2: begin wk_en[0] = 1; wk_rd[PW-1:0] = PW'(v.preg); end
            3: begin spec_en[0] = 1; spec_rd[PW-1:0] = PW'(v.preg); spec_lat[LW-1:0] = LW'(v.lat); end
            4: begin cancel_en[0] = 1; cancel_rd[PW-1:0] = PW'(v.preg); end
            5: begin walk_en[0] = 1; walk_rd[PW-1:0] = PW'(v.preg); end
            6: begin dis_en[0] = 1; dis_rd[PW-1:0] = PW'(v.preg);
                     wk_en[0] = 1; wk_rd[PW-1:0] = PW'(v.preg); end
            7: begin redirect = 1; dis_en[0] = 1; dis_rd[PW-1:0] = PW'(v.preg);
                     walk_en[0] = 1; walk_rd[PW-1:0] = PW'(v.preg); end
            default: ;
        endcase
    endtask

    task automatic check_row(string tag, logic er, logic es, int eb);
        chk({tag, " rd_ready"}, int'(rd_ready), er ? 255 : 0);
        chk({tag, " rd_spec"}, int'(rd_spec), es ? 255 : 0);
        chk({tag, " busy_cnt"}, int'(busy_cnt), eb);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        clear_in();
        set_q(0);
        rst = 1;
        // reset state, then dispatch/wakeup bypass on 10
        tbl.push_back(mk(0, 0, 0, 5, 1, 0, 0));
        tbl.push_back(mk(1, 10, 0, 10, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 10, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 10, 0, 0, 1));
        tbl.push_back(mk(2, 10, 0, 10, 1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 10, 1, 0, 0));
        // schedule lat 2 on 20, then cancel, then walk restore
        tbl.push_back(mk(1, 20, 0, 20, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 20, 0, 0, 1));
        tbl.push_back(mk(3, 20, 2, 20, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 20, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 20, 0, 0, 1));
        tbl.push_back(mk(4, 20, 0, 20, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 20, 0, 0, 1));
        tbl.push_back(mk(5, 20, 0, 20, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 20, 1, 0, 0));
        // saturating latency 7 -> 3 on 21; confirm; cancel ignored
        tbl.push_back(mk(1, 21, 0, 21, 1, 0, 0));
        tbl.push_back(mk(3, 21, 7, 21, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 21, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 21, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 21, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 21, 1, 1, 0));
        tbl.push_back(mk(2, 21, 0, 21, 1, 0, 0));
        tbl.push_back(mk(4, 21, 0, 21, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 21, 1, 0, 0));
        // schedule on confirmed-ready preg is ignored; lat 0 schedule
        tbl.push_back(mk(3, 5, 0, 5, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 5, 1, 0, 0));
        tbl.push_back(mk(1, 22, 0, 22, 1, 0, 0));
        tbl.push_back(mk(3, 22, 0, 22, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 22, 1, 1, 0));
        // same-cycle priority on 30
        tbl.push_back(mk(6, 30, 0, 30, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 30, 0, 0, 1));
        tbl.push_back(mk(7, 30, 0, 30, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 30, 1, 0, 0));

        repeat (3) @(posedge clk);
        #1 rst = 0;
        foreach (tbl[k]) begin
            if (k != 0) begin
                @(posedge clk);
                #1;
            end
            apply(tbl[k]);
            @(negedge clk);
            check_row($sformatf("row%0d", k), tbl[k].er, tbl[k].es, tbl[k].eb);
        end

        // reset while preg 40 is mid-countdown
        @(posedge clk); #1;
        clear_in(); set_q(40);
        dis_en[0] = 1; dis_rd[PW-1:0] = 7'd40;
        @(posedge clk); #1;
        clear_in(); set_q(40);
        spec_en[0] = 1; spec_rd[PW-1:0] = 7'd40; spec_lat[LW-1:0] = 3'd3;
        @(posedge clk); #1;
        clear_in(); set_q(40);
        @(posedge clk); #1;
        check_row("cnt2 pre-reset", 0, 0, 1);
        #2 rst = 1;
        #1 check_row("async reset", 1, 0, 0);
        @(posedge clk); #1 rst = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check_row($sformatf("post-reset c%0d", c), 1, 0, 0);
        end

        // duplicate dispatch ports on 50, wakeup on a non-zero port bypasses
        @(posedge clk); #1;
        clear_in(); set_q(50);
        dis_en = 4'b0011; dis_rd[PW-1:0] = 7'd50; dis_rd[2*PW-1:PW] = 7'd50;
        @(posedge clk); #1;
        clear_in(); set_q(50);
        @(negedge clk);
        check_row("dup dispatch", 0, 0, 1);
        @(posedge clk); #1;
        wk_en[2] = 1; wk_rd[3*PW-1:2*PW] = 7'd50;
        @(negedge clk);
        check_row("port2 bypass", 1, 0, 1);
        @(posedge clk); #1;
        clear_in();
        @(negedge clk);
        check_row("port2 wakeup", 1, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/latency_busy_table.md
LATENCY_BUSY_TABLE -- requirements
Module: latency_busy_table

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- PREG_SIZE, 128, physical registers tracked.
- PREG_WIDTH, $clog2(PREG_SIZE), preg index width.
- DIS_NUM, 4, dispatch rename ports.
- RD_PORT, 8, readiness query ports.
- WAKEUP_NUM, 4, confirmed writeback wakeup ports.
- SPEC_NUM, 2, speculative (latency-scheduled) wakeup/cancel ports.
- WALK_NUM, 4, rollback walk ports.
- MAX_LAT, 3, maximum scheduled latency.
- LAT_W, $clog2(MAX_LAT+1), latency field width.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, sole clock.
- rst, in, 1, asynchronous active-high reset.
- redirect, in, 1, backend redirect; suppresses dispatch clears.
- dis_en, in, DIS_NUM, dispatch valid per port.
- dis_rd, in, DIS_NUM x PREG_WIDTH, newly allocated destination pregs.
- wk_en, in, WAKEUP_NUM, confirmed wakeup valid (includes we).
- wk_rd, in, WAKEUP_NUM x PREG_WIDTH, confirmed wakeup preg.
- spec_en, in, SPEC_NUM, speculative wakeup schedule valid.
- spec_rd, in, SPEC_NUM x PREG_WIDTH, scheduled preg.
- spec_lat, in, SPEC_NUM x LAT_W, cycles until speculative ready.
- cancel_en, in, SPEC_NUM, speculative wakeup cancel (load miss).
- cancel_rd, in, SPEC_NUM x PREG_WIDTH, cancelled preg.
- walk_en, in, WALK_NUM, rollback walk restore valid.
- walk_rd, in, WALK_NUM x PREG_WIDTH, restored preg.
- rd_preg, in, RD_PORT x PREG_WIDTH, query index.
- rd_ready, out, RD_PORT, operand ready.
- rd_spec, out, RD_PORT, operand ready only speculatively.
- busy_cnt, out, PREG_WIDTH+1, registered count of not-ready pregs.

Function
REQ-003 Per-preg state SHALL be ready (1b), spec (1b) and cnt (LAT_W).
REQ-004 Dispatch SHALL clear ready, spec and cnt of dis_rd[i] next cycle when dis_en[i] & ~redirect.
REQ-005 A confirmed wakeup SHALL set ready=1, spec=0, cnt=0 next cycle.
REQ-006 A walk SHALL set ready=1, spec=0, cnt=0 next cycle.
REQ-007 A schedule with effective lat L SHALL mean:
- L = min(spec_lat, MAX_LAT); out-of-range spec_lat saturates to MAX_LAT.
- L=0: ready=1, spec=1 next cycle.
- L>0: cnt=L next cycle.
REQ-008 Any cnt>0 SHALL decrement by 1 per cycle; on the 1->0 transition it sets ready=1, spec=1, so ready is visible exactly L+1 cycles after the spec_en cycle.
REQ-009 A schedule to a preg already ready with spec=0 SHALL be ignored.
REQ-010 Cancel SHALL clear ready, spec and cnt only when spec=1 or cnt>0; a confirmed-ready preg is unaffected.
REQ-011 Same preg, same cycle, priority SHALL be: dispatch > cancel > confirmed wakeup/walk > cnt expiry > new schedule.
REQ-012 rd_ready[j] SHALL be combinational: ready[rd_preg[j]] OR any same-cycle wk_en hit on rd_preg[j] (bypass). Walk, schedule and dispatch are not bypassed.
REQ-013 rd_spec[j] SHALL be spec[rd_preg[j]] AND NOT a same-cycle confirmed-wakeup hit.
REQ-014 busy_cnt SHALL be a registered popcount of ~ready, i.e. the next-state of ready one cycle late.
REQ-015 Duplicate indices across ports SHALL OR-combine; no error.

Reset
REQ-016 On rst=1, asynchronously:
- all ready=1;
- all spec=0 and cnt=0;
- busy_cnt=0.
Counting in flight at reset SHALL be discarded.
REQ-017 Outputs SHALL be valid the first clock after rst deasserts.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- Reset, then query preg 5 -> rd_ready=1, rd_spec=0, busy_cnt=0.
- Dispatch preg 10 at cycle 0 -> rd_ready=0 at cycle 1, busy_cnt=1; wk_en on 10 at cycle 3 -> rd_ready=1 in cycle 3 (bypass), busy_cnt=0 at cycle 4.
- Dispatch 20; spec_en on 20, lat=2 at cycle 2 -> rd_ready=0 in cycles 3-4; rd_ready=1, rd_spec=1 at cycle 5; cancel at cycle 5 -> rd_ready=0 at cycle 6.
- spec_lat=7 with MAX_LAT=3 -> ready 4 cycles later; cancel on a confirmed-ready preg -> stays ready.
- Same cycle on preg 30: dispatch + wk_en -> busy next cycle; dispatch with redirect=1 + walk on 30 -> ready next cycle.
- Assert rst while preg 40 has cnt=2 -> ready=1, cnt=0 immediately; no late spec set afterwards.
